mux8_rr_sched: RTL and testbench
================================

# mux8_rr_sched

Round-robin source scheduler that sits directly upstream of the 16-bit 8-way mux and consumes what it produces. It arbitrates among eight requesting channels and drives the mux select lines `s0`/`s1`/`s2`. It then captures the selected 16-bit `mux_out` word and presents it downstream on a valid/ready interface. It also returns a one-cycle acknowledge to the channel whose word was taken.

## Interface
Parameters:
- `WIDTH`, default 16: data width; must match the mux width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  per-channel request; `req[k]` high means channel k has a word on mux input `in<k>`.
- `mux_out`  in  WIDTH  output of the 8-way mux.
- `s0`  out  1  mux select bit 0 (LSB).
- `s1`  out  1  mux select bit 1.
- `s2`  out  1  mux select bit 2 (MSB); selected channel = {s2,s1,s0}.
- `ack`  out  8  one-hot, one-cycle pulse to the channel whose word was captured.
- `out_data`  out  WIDTH  captured word.
- `out_valid`  out  1  `out_data` holds an untransferred word.
- `out_ready`  in  1  downstream accepts a word when high together with `out_valid`.

## Operation
- FSM states:
  - IDLE: if `req` != 0, grant the first requesting channel strictly after `last`, searching upward and wrapping 7→0. Register the grant onto {s2,s1,s0} and go to CAPTURE. If `req` == 0, stay in IDLE.
  - CAPTURE: if `req[grant]` is still high, load `mux_out` into `out_data`, set `out_valid`, pulse `ack[grant]`, and go to WAIT. If `req[grant]` has dropped, abort: no load, no ack, `last` unchanged, return to IDLE.
  - WAIT: hold `out_data`, `out_valid`, and the select lines stable. On `out_valid && out_ready`, clear `out_valid`, set `last` to grant, and go to IDLE.
- Select lines change only on the IDLE→CAPTURE transition and are otherwise held. This keeps the mux input stable through capture.
- `last` is a 3-bit pointer to the most recently completed channel. Wrap-around is modulo 8.
- A channel whose request is asserted continuously is served at most once per full rotation while other channels request.
- `req` is ignored in WAIT. Changes in `req` during WAIT affect only the next IDLE arbitration.
- `ack` is all-zero except for the single cycle after the CAPTURE edge. At most one bit is ever high.
- Reset (asynchronous, any state, including mid-CAPTURE or mid-WAIT) forces:
  - state IDLE
  - `s0`=`s1`=`s2`=0
  - `ack`=0
  - `out_valid`=0
  - `out_data`=0
  - `last`=7, so that channel 0 wins first after reset.
  - A pending word is discarded and no ack is issued for it.

## Timing
- Reset values of all outputs: `s0`=`s1`=`s2`=0, `ack`=8'h00, `out_data`=0, `out_valid`=0.
- Edge N (IDLE, `req` nonzero): select lines valid after N.
- Edge N+1 (CAPTURE): `out_data`/`out_valid` valid after N+1, and `ack[grant]` high for the cycle N+1..N+2.
- Request-to-`out_valid` latency: 2 cycles.
- Handshake at edge M: `out_valid` is low after M. The earliest next grant is edge M+1, and the earliest next `out_valid` is after M+2.
- Maximum throughput: one word per 3 cycles (`out_ready` held high).
- `out_ready` may be high before `out_valid`. A transfer occurs only on an edge where both are high.
- `out_data` must not change while `out_valid` is high and `out_ready` is low.

## Test plan
- Reset: assert `rst_n`=0 mid-WAIT with `out_valid`=1 → all outputs are 0 immediately (asynchronously). After release with `req`=8'h01, the grant is channel 0.
- Single channel: `req`=8'h20, `in5`=16'hBEEF, `out_ready`=1 → {s2,s1,s0}=3'b101 after edge 1. `out_data`=16'hBEEF, `out_valid`=1, and `ack`=8'h20 after edge 2. `out_valid`=0 after edge 3.
- Round robin: `req`=8'hFF held, `out_ready`=1, `in<k>`=k → `out_data` sequence is 0,1,…,7,0,1, one word every 3 cycles. Each `ack` bit pulses once per rotation.
- Backpressure: as in the single-channel scenario but `out_ready`=0 for 10 cycles → `out_data`, `out_valid`, and the select lines stay constant and no further `ack` occurs. Raising `out_ready` completes the transfer in one edge.
- Abort: `req`=8'h08 for exactly one cycle (seen in IDLE, gone in CAPTURE) → no `out_valid`, `ack`=0, and `last` unchanged. A subsequent `req`=8'h18 grants channel 3 first.
- Wrap: after channel 7 completes, `req`=8'h81 → channel 0 is granted before channel 7.

Source files
------------

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler for an 8-way mux: picks a requesting channel, drives the selects,
// captures the mux word and hands it downstream over valid/ready with a one-cycle ack.
module mux8_rr_sched #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_req,
  input  logic [WIDTH-1:0] i_mux_out,
  output logic             o_s0,
  output logic             o_s1,
  output logic             o_s2,
  output logic [7:0]       o_ack,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  typedef enum logic [1:0] {StIdle, StCapture, StWait} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [2:0]       r_sel;
  logic [2:0]       r_last;
  logic [7:0]       r_ack;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic [2:0]       w_grant;
  logic [2:0]       w_idx;
  logic             w_found;
  logic             w_req_any;
  logic             w_load;
  logic             w_xfer;

  assign w_req_any = |i_req;
  assign w_load    = (r_state == StCapture) && i_req[r_sel];
  assign w_xfer    = (r_state == StWait) && r_valid && i_out_ready;

  // Search upward starting just past the last completed channel; last itself is checked last.
  always_comb begin
    w_grant = r_last;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 1; i <= 8; i++) begin
      w_idx = r_last + 3'(i);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_req_any) w_state_next = StCapture;
      StCapture: w_state_next = w_load ? StWait : StIdle;
      StWait:    if (w_xfer) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel   <= '0;
      r_last  <= 3'd7;
      r_ack   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_ack <= '0;
      if (r_state == StIdle && w_req_any) begin
        r_sel <= w_grant;
      end
      if (w_load) begin
        r_data  <= i_mux_out;
        r_valid <= 1'b1;
        r_ack   <= 8'b1 << r_sel;
      end
      // An aborted capture leaves r_last alone so the same channel keeps its turn.
      if (w_xfer) begin
        r_valid <= 1'b0;
        r_last  <= r_sel;
      end
    end
  end

  always_comb begin
    o_s0        = r_sel[0];
    o_s1        = r_sel[1];
    o_s2        = r_sel[2];
    o_ack       = r_ack;
    o_out_data  = r_data;
    o_out_valid = r_valid;
  end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Scoreboard bench for mux8_rr_sched: a transaction-level model predicts grants and words,
// a negedge monitor compares selects/ack/valid every cycle and the word on every transfer.
module tb_mux8_rr_sched;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   req = 8'h00;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_w [8];
  logic [W-1:0] mux_out;
  logic         s0, s1, s2;
  logic [7:0]   ack;
  logic [W-1:0] out_data;
  logic         out_valid;

  int checks = 0;
  int errors = 0;
  int n_words = 0;

  // Reference model state
  int           m_phase = 0;
  int           m_last = 7;
  int           m_sel = 0;
  logic         m_valid = 1'b0;
  logic [7:0]   m_ack = 8'h00;
  logic [W-1:0] exp_q [$];

  logic [W-1:0] prev_data = '0;
  logic         prev_hold = 1'b0;
  logic [7:0]   acc;

  assign mux_out = in_w[{s2, s1, s0}];

  always #5 clk = ~clk;

  mux8_rr_sched #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_mux_out   (mux_out),
    .o_s0        (s0),
    .o_s1        (s1),
    .o_s2        (s2),
    .o_ack       (ack),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_grant(input int last, input logic [7:0] r);
    for (int d = 1; d <= 8; d++) begin
      if (r[(last + d) % 8]) return (last + d) % 8;
    end
    return last;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: advances one step per clock using the rules for grant, capture/abort and handshake.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0;
        m_last  = 7;
        m_sel   = 0;
        m_valid = 1'b0;
        m_ack   = 8'h00;
        exp_q.delete();
      end else begin
        m_ack = 8'h00;
        case (m_phase)
          0: if (req != 8'h00) begin
            m_sel   = next_grant(m_last, req);
            m_phase = 1;
          end
          1: if (req[m_sel]) begin
            exp_q.push_back(in_w[m_sel]);
            m_ack   = 8'(1 << m_sel);
            m_valid = 1'b1;
            m_phase = 2;
          end else begin
            m_phase = 0;
          end
          default: if (out_ready) begin
            m_valid = 1'b0;
            m_last  = m_sel;
            m_phase = 0;
          end
        endcase
      end
    end
  end

  // Monitor: mid-cycle sampling; a transfer seen here completes at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("sel", 32'({s2, s1, s0}), 32'(m_sel));
        chk("valid", 32'(out_valid), 32'(m_valid));
        chk("ack", 32'(ack), 32'(m_ack));
        if (prev_hold) chk("hold_data", 32'(out_data), 32'(prev_data));
        if (out_valid && out_ready) begin
          n_words++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL data: got %0h expected none (queue empty) at %0t", out_data, $time);
          end else begin
            chk("data", 32'(out_data), 32'(exp_q.pop_front()));
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) in_w[k] = '0;
    #2;
    chk("rst_sel", 32'({s2, s1, s0}), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single channel
    in_w[5] = 16'hBEEF;
    req = 8'h20;
    out_ready = 1'b1;
    tick();
    chk("single_sel", 32'({s2, s1, s0}), 32'h5);
    tick();
    chk("single_data", 32'(out_data), 32'hBEEF);
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_ack", 32'(ack), 32'h20);
    req = 8'h00;
    tick();
    chk("single_done", 32'(out_valid), 32'h0);

    // Abort: one-cycle request, then a two-channel request must still start at channel 3
    tick();
    req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    chk("abort_valid", 32'(out_valid), 32'h0);
    chk("abort_ack", 32'(ack), 32'h0);
    req = 8'h18;
    tick();
    chk("abort_regrant", 32'({s2, s1, s0}), 32'h3);
    tick();
    tick();
    req = 8'h00;
    tick();

    // Backpressure: the word must survive changes on the mux input while waiting
    in_w[5] = 16'hBEEF;
    req = 8'h20;
    out_ready = 1'b0;
    tick();
    tick();
    req = 8'h00;
    in_w[5] = 16'h1234;
    repeat (10) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_data", 32'(out_data), 32'hBEEF);
      chk("bp_sel", 32'({s2, s1, s0}), 32'h5);
      chk("bp_ack", 32'(ack), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", 32'(out_valid), 32'h0);

    // Wrap: complete channel 7, then channel 0 beats channel 7
    req = 8'h80;
    tick();
    tick();
    tick();
    req = 8'h81;
    tick();
    chk("wrap_sel", 32'({s2, s1, s0}), 32'h0);
    tick();
    tick();
    req = 8'h00;
    tick();
    tick();

    // Round robin over all channels
    for (int k = 0; k < 8; k++) in_w[k] = W'(k);
    req = 8'hFF;
    acc = 8'h00;
    repeat (24) begin
      tick();
      acc = acc | ack;
    end
    chk("rr_all_acked", 32'(acc), 32'hFF);
    req = 8'h00;
    repeat (3) tick();

    // Asynchronous reset while a word is waiting
    req = 8'h01;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_pre_valid", 32'(out_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'({s2, s1, s0}), 32'h0);
    chk("arst_ack", 32'(ack), 32'h0);
    chk("arst_data", 32'(out_data), 32'h0);
    chk("arst_valid", 32'(out_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("arst_regrant", 32'({s2, s1, s0}), 32'h0);
    repeat (3) tick();

    // Randomized traffic with occasional request drops and one mid-run reset
    for (int c = 0; c < 800; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 9) == 0) req = 8'h00;
      out_ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 8; k++) in_w[k] = W'($urandom);
      if (c == 400) begin
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end

    req = 8'h00;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'h0);
    chk("words_seen", 32'(n_words > 100), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
